// File: rtl/ysyx_201979054_block_transfer_engine.sv
// Cache block refill/writeback engine in front of an AXI4 master. High memory uses one burst per
// block, low memory uses one single-beat transfer per narrow word, plus uncached byte access.
module ysyx_201979054_block_transfer_engine #(
  parameter int unsigned       BLOCK_W    = 512,
  parameter int unsigned       BUS_W      = 64,
  parameter int unsigned       NARROW_W   = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BURST_BASE = 32'h4000_0000
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               i_rd_req,
  input  logic               i_wr_req,
  input  logic               i_nc_rd_req,
  input  logic               i_nc_wr_req,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [ADDR_W-1:0]  i_nc_addr,
  input  logic [BLOCK_W-1:0] i_block_wdata,
  input  logic [7:0]         i_nc_wdata,
  output logic [BLOCK_W-1:0] o_block_rdata,
  output logic [7:0]         o_nc_rdata,
  output logic               o_done,
  output logic               o_busy,
  output logic               o_bus_rd_req,
  output logic               o_bus_wr_req,
  output logic [ADDR_W-1:0]  o_bus_addr,
  output logic [7:0]         o_bus_len,
  output logic [2:0]         o_bus_size,
  output logic [BUS_W/8-1:0] o_bus_strb,
  output logic [BUS_W-1:0]   o_bus_wdata,
  input  logic               i_bus_beat,
  input  logic [BUS_W-1:0]   i_bus_rdata,
  input  logic               i_bus_done
);
  localparam int unsigned BurstBeats = BLOCK_W / BUS_W;
  localparam int unsigned SplitWords = BLOCK_W / NARROW_W;
  localparam int unsigned MaxBeats   = (BurstBeats > SplitWords) ? BurstBeats : SplitWords;
  localparam int unsigned CntW       = $clog2(MaxBeats) + 1;
  localparam int unsigned StrbW      = BUS_W / 8;
  localparam int unsigned NarrowB    = NARROW_W / 8;
  localparam int unsigned SplitRep   = BUS_W / NARROW_W;

  localparam logic [CntW-1:0]  BurstCnt   = CntW'(BurstBeats);
  localparam logic [CntW-1:0]  BurstLast  = CntW'(BurstBeats - 1);
  localparam logic [CntW-1:0]  SplitLast  = CntW'(SplitWords - 1);
  localparam logic [7:0]       BurstLen   = 8'(BurstBeats - 1);
  localparam logic [2:0]       BusSize    = 3'($clog2(StrbW));
  localparam logic [2:0]       NarrowSize = 3'($clog2(NarrowB));
  localparam logic [StrbW-1:0] NarrowStrb = StrbW'((1 << NarrowB) - 1);

  typedef enum logic [2:0] {
    StIdle, StRdBurst, StWrBurst, StRdSplit, StWrSplit, StGap, StNc, StDone
  } state_e;

  state_e             state_q, state_d;
  logic               wr_q, wr_d;
  logic               nc_wr_q, nc_wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] blk_wdata_q, blk_wdata_d;
  logic [7:0]         nc_wdata_q, nc_wdata_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [CntW-1:0]    word_q, word_d;
  logic [BLOCK_W-1:0] blk_rdata_q, blk_rdata_d;
  logic [7:0]         nc_rdata_q, nc_rdata_d;

  logic [CntW-1:0]     burst_idx;
  logic [NARROW_W-1:0] split_word;
  logic [ADDR_W-1:0]   split_addr;

  // Write word index saturates so stray beats past the block never select outside it.
  assign burst_idx  = (cnt_q < BurstCnt) ? cnt_q : BurstLast;
  assign split_word = blk_wdata_q[word_q * NARROW_W +: NARROW_W];
  assign split_addr = addr_q + (ADDR_W'(word_q) << $clog2(NarrowB));

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      nc_wr_q     <= 1'b0;
      addr_q      <= '0;
      blk_wdata_q <= '0;
      nc_wdata_q  <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      blk_rdata_q <= '0;
      nc_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      nc_wr_q     <= nc_wr_d;
      addr_q      <= addr_d;
      blk_wdata_q <= blk_wdata_d;
      nc_wdata_q  <= nc_wdata_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      blk_rdata_q <= blk_rdata_d;
      nc_rdata_q  <= nc_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    nc_wr_d     = nc_wr_q;
    addr_d      = addr_q;
    blk_wdata_d = blk_wdata_q;
    nc_wdata_d  = nc_wdata_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    blk_rdata_d = blk_rdata_q;
    nc_rdata_d  = nc_rdata_q;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        word_d = '0;
        if (i_nc_rd_req || i_nc_wr_req) begin
          nc_wr_d = !i_nc_rd_req;
          addr_d  = i_nc_addr;
          if (!i_nc_rd_req) nc_wdata_d = i_nc_wdata;
          state_d = StNc;
        end else if (i_rd_req || i_wr_req) begin
          wr_d   = !i_rd_req;
          addr_d = i_addr;
          if (!i_rd_req) blk_wdata_d = i_block_wdata;
          if (i_addr >= BURST_BASE) state_d = i_rd_req ? StRdBurst : StWrBurst;
          else                      state_d = i_rd_req ? StRdSplit : StWrSplit;
        end
      end
      StRdBurst, StWrBurst: begin
        if (i_bus_beat && (cnt_q < BurstCnt)) begin
          if (state_q == StRdBurst) blk_rdata_d[cnt_q * BUS_W +: BUS_W] = i_bus_rdata;
          cnt_d = cnt_q + CntW'(1);
        end
        if (i_bus_done) state_d = StDone;
      end
      StRdSplit, StWrSplit: begin
        // cnt_q tracks beats within the current single-beat transaction only.
        if (i_bus_beat && (cnt_q == '0)) begin
          if (state_q == StRdSplit) begin
            blk_rdata_d[word_q * NARROW_W +: NARROW_W] = i_bus_rdata[NARROW_W-1:0];
          end
          cnt_d = CntW'(1);
        end
        if (i_bus_done) begin
          cnt_d = '0;
          if (word_q == SplitLast) begin
            state_d = StDone;
          end else begin
            word_d  = word_q + CntW'(1);
            state_d = StGap;
          end
        end
      end
      StGap: state_d = wr_q ? StWrSplit : StRdSplit;
      StNc: begin
        if (i_bus_beat && (cnt_q == '0)) begin
          if (!nc_wr_q) nc_rdata_d = i_bus_rdata[7:0];
          cnt_d = CntW'(1);
        end
        if (i_bus_done) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_bus_rd_req = 1'b0;
    o_bus_wr_req = 1'b0;
    o_bus_addr   = '0;
    o_bus_len    = '0;
    o_bus_size   = '0;
    o_bus_strb   = '0;
    o_bus_wdata  = '0;
    unique case (state_q)
      StRdBurst, StWrBurst: begin
        o_bus_rd_req = (state_q == StRdBurst);
        o_bus_wr_req = (state_q == StWrBurst);
        o_bus_addr   = addr_q;
        o_bus_len    = BurstLen;
        o_bus_size   = BusSize;
        o_bus_strb   = '1;
        o_bus_wdata  = blk_wdata_q[burst_idx * BUS_W +: BUS_W];
      end
      StRdSplit, StWrSplit, StGap: begin
        o_bus_rd_req = (state_q == StRdSplit);
        o_bus_wr_req = (state_q == StWrSplit);
        o_bus_addr   = split_addr;
        o_bus_size   = NarrowSize;
        o_bus_strb   = NarrowStrb;
        o_bus_wdata  = {SplitRep{split_word}};
      end
      StNc: begin
        o_bus_rd_req = !nc_wr_q;
        o_bus_wr_req = nc_wr_q;
        o_bus_addr   = addr_q;
        o_bus_strb   = StrbW'(1);
        o_bus_wdata  = {StrbW{nc_wdata_q}};
      end
      default: ;
    endcase
  end

  assign o_done        = (state_q == StDone);
  assign o_busy        = (state_q != StIdle);
  assign o_block_rdata = blk_rdata_q;
  assign o_nc_rdata    = nc_rdata_q;

endmodule

// File: tb/tb_ysyx_201979054_block_transfer_engine.sv
// Scoreboard bench: requests push expected bus transactions and results into queues; a bus
// responder and a completion monitor pop and compare independently.
module tb_ysyx_201979054_block_transfer_engine;
  logic         clk = 1'b0;
  logic         arst;
  logic         i_rd_req, i_wr_req, i_nc_rd_req, i_nc_wr_req;
  logic [31:0]  i_addr, i_nc_addr;
  logic [511:0] i_block_wdata;
  logic [7:0]   i_nc_wdata;
  logic [511:0] o_block_rdata;
  logic [7:0]   o_nc_rdata;
  logic         o_done, o_busy, o_bus_rd_req, o_bus_wr_req;
  logic [31:0]  o_bus_addr;
  logic [7:0]   o_bus_len;
  logic [2:0]   o_bus_size;
  logic [7:0]   o_bus_strb;
  logic [63:0]  o_bus_wdata;
  logic         i_bus_beat, i_bus_done;
  logic [63:0]  i_bus_rdata;

  ysyx_201979054_block_transfer_engine dut (
    .clk(clk), .arst(arst),
    .i_rd_req(i_rd_req), .i_wr_req(i_wr_req), .i_nc_rd_req(i_nc_rd_req),
    .i_nc_wr_req(i_nc_wr_req), .i_addr(i_addr), .i_nc_addr(i_nc_addr),
    .i_block_wdata(i_block_wdata), .i_nc_wdata(i_nc_wdata),
    .o_block_rdata(o_block_rdata), .o_nc_rdata(o_nc_rdata), .o_done(o_done), .o_busy(o_busy),
    .o_bus_rd_req(o_bus_rd_req), .o_bus_wr_req(o_bus_wr_req), .o_bus_addr(o_bus_addr),
    .o_bus_len(o_bus_len), .o_bus_size(o_bus_size), .o_bus_strb(o_bus_strb),
    .o_bus_wdata(o_bus_wdata), .i_bus_beat(i_bus_beat), .i_bus_rdata(i_bus_rdata),
    .i_bus_done(i_bus_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [7:0]  strb;
    int          nbeats;
    bit          extra;
    bit          cont;
  } txn_t;

  // kind: 0 block read, 1 any write, 2 uncached read
  typedef struct {
    int           kind;
    logic [511:0] blk;
    logic [7:0]   nc;
  } res_t;

  txn_t        exp_txn_q[$];
  logic [63:0] exp_wdata_q[$];
  logic [63:0] rdata_q[$];
  res_t        exp_res_q[$];

  logic [511:0] model_blk = '0;
  logic [7:0]   model_nc  = '0;
  int  checks = 0;
  int  passes = 0;
  bit  resp_en = 1'b0;
  bit  abort = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: expands one request into its expected bus transactions and final result.
  task automatic do_req(input int kind, input logic [31:0] a, input logic [7:0] ncb,
                        input bit seq, input int short_n, input bit extra);
    txn_t t;
    res_t r;
    logic [511:0] wblk;
    logic [63:0] d;
    bit burst;
    int n;
    wblk  = rand512();
    burst = (a >= 32'h4000_0000);
    if (kind == 0 || kind == 1) begin
      if (burst) begin
        n = (short_n > 0) ? short_n : 8;
        t = '{rd: (kind == 0), addr: a, len: 8'd7, size: 3'd3, strb: 8'hFF, nbeats: n,
              extra: extra, cont: 1'b0};
        exp_txn_q.push_back(t);
        for (int k = 0; k < n; k++) begin
          if (kind == 0) begin
            d = seq ? 64'(k) : {$urandom, $urandom};
            rdata_q.push_back(d);
            model_blk[k*64 +: 64] = d;
          end else begin
            exp_wdata_q.push_back(wblk[k*64 +: 64]);
          end
        end
      end else begin
        for (int k = 0; k < 16; k++) begin
          t = '{rd: (kind == 0), addr: a + 32'(4 * k), len: 8'd0, size: 3'd2, strb: 8'h0F,
                nbeats: 1, extra: 1'b0, cont: (k > 0)};
          exp_txn_q.push_back(t);
          if (kind == 0) begin
            d = {$urandom, $urandom};
            rdata_q.push_back(d);
            model_blk[k*32 +: 32] = d[31:0];
          end else begin
            exp_wdata_q.push_back({2{wblk[k*32 +: 32]}});
          end
        end
      end
    end else begin
      t = '{rd: (kind != 3), addr: a, len: 8'd0, size: 3'd0, strb: 8'h01, nbeats: 1,
            extra: 1'b0, cont: 1'b0};
      exp_txn_q.push_back(t);
      if (kind != 3) begin
        d = {$urandom, $urandom};
        rdata_q.push_back(d);
        model_nc = d[7:0];
      end else begin
        exp_wdata_q.push_back({8{ncb}});
      end
    end
    r.kind = (kind == 0) ? 0 : ((kind == 1 || kind == 3) ? 1 : 2);
    r.blk  = model_blk;
    r.nc   = model_nc;
    exp_res_q.push_back(r);

    unique case (kind)
      0: begin i_rd_req = 1'b1; i_addr = a; end
      1: begin i_wr_req = 1'b1; i_addr = a; i_block_wdata = wblk; end
      2: begin i_nc_rd_req = 1'b1; i_nc_addr = a; i_wr_req = 1'($urandom); end
      3: begin i_nc_wr_req = 1'b1; i_nc_addr = a; i_nc_wdata = ncb; i_rd_req = 1'($urandom); end
      default: begin i_nc_rd_req = 1'b1; i_nc_addr = a; i_rd_req = 1'b1;
                     i_addr = 32'h8000_0000; end
    endcase
    @(posedge clk); #1;
    i_rd_req = 0; i_wr_req = 0; i_nc_rd_req = 0; i_nc_wr_req = 0;
    // Requests while busy must be ignored.
    i_wr_req = 1'b1; i_nc_rd_req = 1'b1; i_addr = $urandom; i_nc_addr = $urandom;
    @(posedge clk); #1;
    i_wr_req = 0; i_nc_rd_req = 0;
    n = 0;
    while (exp_res_q.size() != 0 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_res_q.size() != 0) begin
      checks++;
      $display("FAIL completion_timeout: got %0d results pending, expected 0", exp_res_q.size());
      abort = 1'b1;
    end else begin
      chk("idle_after_done", 512'(o_busy), 512'(0));
    end
  endtask

  // Completion monitor.
  always @(negedge clk) begin
    if (resp_en && arst && o_done) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got o_done=1, expected no completion");
      end else begin
        res_t r;
        r = exp_res_q.pop_front();
        if (r.kind == 0) chk("block_rdata", o_block_rdata, r.blk);
        else if (r.kind == 2) chk("nc_rdata", 512'(o_nc_rdata), 512'(r.nc));
        else chk("write_done_busy", 512'(o_busy), 512'(1));
      end
    end
  end

  // Bus responder: checks request fields, supplies beats, checks write data per beat.
  initial begin
    txn_t t;
    int gap;
    i_bus_beat = 0; i_bus_done = 0; i_bus_rdata = '0;
    wait (resp_en);
    forever begin
      gap = 0;
      while (!(o_bus_rd_req || o_bus_wr_req)) begin
        @(posedge clk); #1;
        gap++;
      end
      if (exp_txn_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_txn: got request at %0h, expected none", o_bus_addr);
        t = '{rd: o_bus_rd_req, addr: 0, len: 0, size: 0, strb: 0, nbeats: 1, extra: 0, cont: 0};
      end else begin
        t = exp_txn_q.pop_front();
        if (t.cont) chk("split_gap", 512'(gap), 512'(1));
        chk("bus_dir", 512'({o_bus_rd_req, o_bus_wr_req}), 512'({t.rd, !t.rd}));
        chk("bus_addr", 512'(o_bus_addr), 512'(t.addr));
        chk("bus_len", 512'(o_bus_len), 512'(t.len));
        chk("bus_size", 512'(o_bus_size), 512'(t.size));
        chk("bus_strb", 512'(o_bus_strb), 512'(t.strb));
      end
      for (int b = 0; b < t.nbeats; b++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        if (!t.rd && exp_wdata_q.size() != 0) begin
          chk("bus_wdata", 512'(o_bus_wdata), 512'(exp_wdata_q.pop_front()));
        end
        i_bus_beat  = 1'b1;
        i_bus_rdata = (t.rd && rdata_q.size() != 0) ? rdata_q.pop_front() : {$urandom, $urandom};
        i_bus_done  = (b == t.nbeats - 1) && !t.extra;
        @(posedge clk); #1;
        i_bus_beat = 0; i_bus_done = 0;
      end
      if (t.extra) begin
        i_bus_beat = 1'b1; i_bus_rdata = {$urandom, $urandom}; i_bus_done = 1'b1;
        @(posedge clk); #1;
        i_bus_beat = 0; i_bus_done = 0;
      end
      chk("req_drop", 512'({o_bus_rd_req, o_bus_wr_req}), 512'(0));
    end
  end

  initial begin
    logic [511:0] part;
    int kind;
    logic [31:0] a;
    bit burst;
    int sn;
    bit ex;
    arst = 0;
    i_rd_req = 0; i_wr_req = 0; i_nc_rd_req = 0; i_nc_wr_req = 0;
    i_addr = 0; i_nc_addr = 0; i_block_wdata = 0; i_nc_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 512'(o_busy), 512'(0));
    chk("rst_done", 512'(o_done), 512'(0));
    chk("rst_reqs", 512'({o_bus_rd_req, o_bus_wr_req}), 512'(0));
    chk("rst_block_rdata", o_block_rdata, 512'(0));
    chk("rst_nc_rdata", 512'(o_nc_rdata), 512'(0));

    // Accept on the first edge after release, then reset in the middle of a burst.
    arst = 1; i_rd_req = 1; i_addr = 32'h8000_0000;
    @(posedge clk); #1;
    i_rd_req = 0;
    chk("first_edge_accept", 512'({o_busy, o_bus_rd_req}), 512'(2'b11));
    chk("burst_len", 512'(o_bus_len), 512'(7));
    chk("burst_size", 512'(o_bus_size), 512'(3));
    part = '0;
    for (int k = 0; k < 3; k++) begin
      i_bus_beat = 1; i_bus_rdata = 64'hDEAD_0000 + 64'(k);
      part[k*64 +: 64] = 64'hDEAD_0000 + 64'(k);
      @(posedge clk); #1;
    end
    i_bus_beat = 0;
    chk("partial_rdata", o_block_rdata, part);
    arst = 0;
    #1;
    chk("midburst_rst_reqs", 512'({o_bus_rd_req, o_bus_wr_req, o_busy, o_done}), 512'(0));
    chk("midburst_rst_rdata", o_block_rdata, 512'(0));
    @(negedge clk);
    arst = 1;
    @(posedge clk); #1;
    resp_en = 1;

    do_req(0, 32'h8000_0000, 8'h00, 1'b1, 0, 1'b0);
    if (!abort) do_req(1, 32'h2000_0000, 8'h00, 1'b0, 0, 1'b0);
    if (!abort) do_req(4, 32'h1234_5677, 8'h00, 1'b0, 0, 1'b0);
    if (!abort) do_req(3, 32'h0000_0013, 8'hA5, 1'b0, 0, 1'b0);
    if (!abort) do_req(0, 32'h4000_0000, 8'h00, 1'b0, 0, 1'b1);
    if (!abort) do_req(0, 32'h3FFF_FFC0, 8'h00, 1'b0, 0, 1'b0);
    if (!abort) do_req(0, 32'hC000_0040, 8'h00, 1'b0, 5, 1'b0);

    for (int i = 0; i < 30 && !abort; i++) begin
      kind  = $urandom_range(0, 3);
      burst = 1'($urandom);
      if (kind >= 2)  a = $urandom;
      else if (burst) a = ($urandom | 32'h4000_0000) & 32'hFFFF_FFC0;
      else            a = $urandom & 32'h3FFF_FFC0;
      sn = (kind == 0 && burst && $urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      ex = (kind == 0 && sn == 0 && $urandom_range(0, 4) == 0);
      do_req(kind, a, 8'($urandom), 1'b0, sn, ex);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("txns_consumed", 512'(exp_txn_q.size()), 512'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_201979054_block_transfer_engine.md
YSYX_201979054_BLOCK_TRANSFER_ENGINE -- requirements
Module: ysyx_201979054_block_transfer_engine

Interface
Parameters (name, default, meaning):
REQ-001 BLOCK_W, 512, cache block width in bits; SHALL be a multiple of BUS_W and NARROW_W.
REQ-002 BUS_W, 64, bus data width in bits (power of two, 32 or 64).
REQ-003 NARROW_W, 32, word width for split-mode regions (power of two, 8..BUS_W).
REQ-004 ADDR_W, 32, address width.
REQ-005 BURST_BASE, 32'h4000_0000; addresses >= BURST_BASE use burst mode, lower addresses use split mode.

Ports (name, direction, width, meaning):
REQ-006 clk  in  1  sole clock; all state changes on the rising edge.
REQ-007 arst  in  1  asynchronous, active-low reset.
REQ-008 i_rd_req / i_wr_req  in  1 each  block refill / block writeback request.
REQ-009 i_nc_rd_req / i_nc_wr_req  in  1 each  uncached single-byte read / write request.
REQ-010 i_addr / i_nc_addr  in  ADDR_W each  block-aligned block address / byte address.
REQ-011 i_block_wdata  in  BLOCK_W; i_nc_wdata  in  8  write data.
REQ-012 o_block_rdata  out  BLOCK_W; o_nc_rdata  out  8  read results.
REQ-013 o_done  out  1  one-cycle completion pulse; o_busy  out  1  engine not in IDLE.
REQ-014 o_bus_rd_req, o_bus_wr_req  out  1; o_bus_addr  out  ADDR_W; o_bus_len  out  8; o_bus_size  out  3; o_bus_strb  out  BUS_W/8; o_bus_wdata  out  BUS_W  request side to the AXI4 master.
REQ-015 i_bus_beat  in  1 (one data beat transferred); i_bus_rdata  in  BUS_W; i_bus_done  in  1 (transaction complete)  response side from the AXI4 master.

Function
REQ-016 States SHALL be IDLE, RD_BURST, WR_BURST, RD_SPLIT, WR_SPLIT, GAP, NC, DONE.
REQ-017 Requests SHALL be sampled only in IDLE; priority nc_rd > nc_wr > rd > wr; address and write data latched on acceptance; requests while busy ignored.
REQ-018 Burst mode (i_addr >= BURST_BASE): one transaction, o_bus_len = BLOCK_W/BUS_W-1, o_bus_size = log2(BUS_W/8), o_bus_strb all ones, o_bus_addr = latched address.
REQ-019 Split mode: BLOCK_W/NARROW_W single-beat transactions, o_bus_len = 0, o_bus_size = log2(NARROW_W/8), o_bus_strb low NARROW_W/8 bits set, address incremented by NARROW_W/8 per word, wdata word replicated across BUS_W.
REQ-020 NC mode: o_bus_len = 0, o_bus_size = 0, o_bus_strb = 1 (bit 0), wdata byte replicated BUS_W/8 times, o_bus_addr = latched i_nc_addr.
REQ-021 o_bus_rd_req / o_bus_wr_req SHALL be held high from state entry until the cycle i_bus_done is sampled, then deasserted.
REQ-022 Split mode SHALL pass through GAP (requests low, one cycle) between consecutive words.
REQ-023 Read data: each i_bus_beat shifts the beat (burst: BUS_W bits; split: low NARROW_W bits) into o_block_rdata, first beat lands in the least-significant word; NC read captures i_bus_rdata[7:0] into o_nc_rdata.
REQ-024 Write data: burst beat k and split word k SHALL present word k of the latched block, LSB word first, advancing on i_bus_beat.
REQ-025 Beat counter width SHALL be clog2(max(BLOCK_W/BUS_W, BLOCK_W/NARROW_W))+1; beats beyond the expected count SHALL be ignored.
REQ-026 Completion: final i_bus_done -> DONE; o_done high exactly in the DONE cycle, then IDLE; o_busy low only in IDLE.
REQ-027 o_block_rdata and o_nc_rdata SHALL hold their values until the next read of the same kind is accepted.
REQ-028 i_bus_done arriving with fewer beats than expected SHALL still complete; unreceived words keep previous contents.

Reset
REQ-029 arst low SHALL immediately force IDLE, all bus requests, o_done and o_busy to 0, counters to 0, o_block_rdata and o_nc_rdata to 0, regardless of state.
REQ-030 After arst release, the first request SHALL be accepted on the first clk edge.

Verification
REQ-031 Burst read at 0x8000_0000, 8 beats 0x0..0x7 -> len=7, size=3, strb=0xFF, o_block_rdata word k = k, o_done one cycle after i_bus_done.
REQ-032 Split write at 0x2000_0000 -> 16 transactions, addresses 0x2000_0000..0x2000_003C, strb=0x0F, one-cycle request gap each, single o_done.
REQ-033 Simultaneous i_nc_rd_req and i_rd_req -> NC read served first (size=0, strb=0x01), block read ignored unless still asserted in IDLE.
REQ-034 NC write 0xA5 -> o_bus_wdata = 0xA5A5_A5A5_A5A5_A5A5, strb=0x01.
REQ-035 arst low mid-burst (after beat 3) -> requests drop same cycle, o_block_rdata = 0; next read completes normally.
REQ-036 Extra i_bus_beat after 8th beat in burst read -> o_block_rdata unchanged.
